ysyx_040066_if_stage: RTL and testbench
=======================================

Name: ysyx_040066_if_stage

Overview:
Instruction-fetch stage that sits directly upstream of the decode stage. It owns the fetch PC and issues single-outstanding requests on a variable-latency 64-bit instruction bus. Fetched (pc, instr, error) triples are buffered in a 2-entry queue and handed to decode under decode's `block` stall. Control-flow redirects (`jmp`) flush the queue and discard any in-flight response.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, fetch PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, value driven on instr_out when no instruction has been handed over, and the payload used for misaligned entries.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- block  in  1  decode stall; no handoff while high.
- jmp  in  1  redirect strobe from downstream.
- jmp_pc  in  64  redirect target, valid when jmp=1.
- imem_req_valid  out  1  bus request valid.
- imem_req_addr  out  64  bus request address, 8-byte aligned (fetch pc with [2:0] cleared).
- imem_req_ready  in  1  bus accepts request.
- imem_resp_valid  in  1  response beat.
- imem_resp_data  in  64  response data; pc[2] selects the upper or lower word.
- imem_resp_error  in  1  bus access fault.
- valid_out  out  1  head entry offered to decode (to valid_in).
- pc_out  out  64  head entry pc (to pc_in).
- instr_out  out  32  instruction of the last entry handed over (to instr_read).
- instr_error_out  out  1  fault of the last entry handed over (to instr_error_rd).

Behaviour:
- Reset (rst=1 at posedge), regardless of any in-flight request:
  - fetch_pc=RESET_PC; queue empty; FSM=IDLE.
  - imem_req_valid=0; valid_out=0; pc_out=0.
  - instr_out=NOP_INSTR; instr_error_out=0.
- Handoff:
  - valid_out = queue_nonempty && ~jmp (combinational); pc_out = head pc.
  - At a posedge with valid_out=1 and block=0: pop the head. In the same edge register the head instr into instr_out and the head err into instr_error_out. Decode therefore sees pc at cycle N and the instruction at cycle N+1.
  - While block=1, the queue, instr_out and instr_error_out hold.
- Queue: 2 entries, FIFO order. Push and pop in the same cycle are allowed. Occupancy never exceeds 2.
- Issue condition: occupancy + outstanding < 2, FSM=IDLE, jmp=0.
- FSM:
  - IDLE:
    - Issue condition true and fetch_pc[1:0]==0: go to REQ and latch req_pc=fetch_pc.
    - Issue condition true and fetch_pc misaligned: no bus request. Push {fetch_pc, NOP_INSTR, err=1}; fetch_pc += 4; stay IDLE.
  - REQ:
    - imem_req_valid=1; address is stable until acceptance.
    - On imem_req_ready: fetch_pc=req_pc+4; go to WAIT (or DROP if jmp in the same cycle).
    - jmp in REQ: the request still completes, then DROP.
  - WAIT:
    - On imem_resp_valid: push {req_pc, word selected by req_pc[2], imem_resp_error}; go to IDLE.
    - jmp without resp: go to DROP.
    - jmp with resp in the same cycle: discard the response, go to IDLE.
  - DROP:
    - On imem_resp_valid: discard, go to IDLE.
    - A further jmp stays in DROP.
- Redirect (jmp=1 at posedge): queue cleared; fetch_pc=jmp_pc. jmp has priority over push, pop, block and fetch_pc increment. No handoff happens in a jmp cycle. instr_out and instr_error_out hold.
- Arithmetic: fetch_pc+4 is modulo 2^64 (wrap from 64'hFFFF_FFFF_FFFF_FFFC to 0 is legal).
- Responses are accepted at the earliest one cycle after acceptance. A response arriving in IDLE/REQ is a protocol violation; ignore it.

Test Plan:
- Reset, ready and resp always 1, one-cycle latency, mem[0x8000_0000]=64'h00A0_0093_0010_0113:
  - req addr 0x8000_0000.
  - valid_out with pc_out 0x8000_0000, then the next cycle instr_out=32'h0010_0113.
  - Next, pc_out 0x8000_0004 followed by instr_out=32'h00A0_0093.
- Hold block=1 for 5 cycles with 2 entries queued:
  - imem_req_valid=0, queue holds, pc_out stable.
  - On release, pcs are handed over in order with no loss or duplication.
- jmp_pc=0x8000_0100 asserted in WAIT, response arrives 3 cycles later:
  - Response discarded; next request addr 0x8000_0100.
  - valid_out=0 during the jmp cycle.
- jmp in the same cycle as imem_resp_valid:
  - Response not pushed.
  - FSM IDLE next cycle; the request for jmp_pc issues the following cycle.
- jmp_pc=0x8000_0102:
  - No bus request.
  - Handoff of pc 0x8000_0102 with instr_out=32'h0000_0013, instr_error_out=1.
  - Next fetch pc 0x8000_0106 (also misaligned, error).
- imem_resp_error=1 on fetch of 0x8000_0008:
  - instr_error_out=1 on handoff.
  - rst asserted mid-WAIT returns to RESET_PC, and a late response is ignored.

Source files
------------

// File: rtl/ysyx_040066_if_stage.sv
// Instruction fetch stage: single-outstanding requests on a 64-bit instruction
// bus, with a 2-entry (pc, instr, err) queue feeding decode under its stall.
module ysyx_040066_if_stage #(
   parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        block,
   input  logic        jmp,
   input  logic [63:0] jmp_pc,
   output logic        imem_req_valid,
   output logic [63:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [63:0] imem_resp_data,
   input  logic        imem_resp_error,
   output logic        valid_out,
   output logic [63:0] pc_out,
   output logic [31:0] instr_out,
   output logic        instr_error_out
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_e;

   state_e      state_q, state_d;
   logic [63:0] fetch_pc_q, fetch_pc_d;
   logic [63:0] req_pc_q, req_pc_d;
   logic        drop_q, drop_d;

   logic [63:0] q_pc_q    [2];
   logic [31:0] q_instr_q [2];
   logic        q_err_q   [2];
   logic        rd_ptr_q, wr_ptr_q;
   logic [1:0]  count_q;

   logic [31:0] instr_q;
   logic        instr_err_q;

   logic        issue, pop, push;
   logic [63:0] push_pc;
   logic [31:0] push_instr;
   logic        push_err;
   logic [31:0] resp_word;

   assign resp_word       = req_pc_q[2] ? imem_resp_data[63:32] : imem_resp_data[31:0];
   assign valid_out       = (count_q != 2'd0) && !jmp;
   assign pc_out          = (count_q != 2'd0) ? q_pc_q[rd_ptr_q] : 64'd0;
   assign pop             = valid_out && !block;
   assign issue           = (state_q == S_IDLE) && (count_q < 2'd2) && !jmp;
   assign instr_out       = instr_q;
   assign instr_error_out = instr_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RESET_PC;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         drop_q     <= drop_d;
      end
      req_pc_q <= req_pc_d;
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      drop_d     = drop_q;
      push       = 1'b0;
      push_pc    = req_pc_q;
      push_instr = resp_word;
      push_err   = imem_resp_error;
      unique case (state_q)
         S_IDLE: begin
            if (issue) begin
               if (fetch_pc_q[1:0] == 2'b00) begin
                  state_d  = S_REQ;
                  req_pc_d = fetch_pc_q;
               end else begin
                  // Misaligned fetch never reaches the bus; it becomes a faulting NOP.
                  push       = 1'b1;
                  push_pc    = fetch_pc_q;
                  push_instr = NOP_INSTR;
                  push_err   = 1'b1;
                  fetch_pc_d = fetch_pc_q + 64'd4;
               end
            end
         end
         S_REQ: begin
            if (imem_req_ready) begin
               state_d = (jmp || drop_q) ? S_DROP : S_WAIT;
               drop_d  = 1'b0;
               if (!drop_q) fetch_pc_d = req_pc_q + 64'd4;
            end else if (jmp) begin
               drop_d = 1'b1;
            end
         end
         S_WAIT: begin
            if (imem_resp_valid) begin
               state_d = S_IDLE;
               push    = !jmp;
            end else if (jmp) begin
               state_d = S_DROP;
            end
         end
         S_DROP: begin
            if (imem_resp_valid) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // A redirect overrides every other fetch-pc update, including a pending drop.
      if (jmp) fetch_pc_d = jmp_pc;
   end

   always_comb begin
      imem_req_valid = (state_q == S_REQ);
      imem_req_addr  = {req_pc_q[63:3], 3'b000};
   end

   always_ff @(posedge clk) begin
      if (rst || jmp) begin
         count_q  <= 2'd0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
      end else begin
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
         if (push) wr_ptr_q <= ~wr_ptr_q;
         count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_pc_q[wr_ptr_q]    <= push_pc;
         q_instr_q[wr_ptr_q] <= push_instr;
         q_err_q[wr_ptr_q]   <= push_err;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q     <= NOP_INSTR;
         instr_err_q <= 1'b0;
      end else if (pop) begin
         instr_q     <= q_instr_q[rd_ptr_q];
         instr_err_q <= q_err_q[rd_ptr_q];
      end
   end

endmodule

// File: tb/tb_ysyx_040066_if_stage.sv
// Bench for ysyx_040066_if_stage: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the fetch stage.
module tb_ysyx_040066_if_stage;

   localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [63:0] ERR_ADDR = 64'h0000_0000_8000_0008;

   logic        clk = 1'b0;
   logic        rst = 1'b1, block = 1'b0, jmp = 1'b0;
   logic [63:0] jmp_pc = 64'd0;
   logic        imem_req_valid, imem_req_ready = 1'b0;
   logic [63:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0, imem_resp_error = 1'b0;
   logic [63:0] imem_resp_data = 64'd0;
   logic        valid_out, instr_error_out;
   logic [63:0] pc_out;
   logic [31:0] instr_out;

   always #5 clk = ~clk;

   ysyx_040066_if_stage dut (
      .clk(clk), .rst(rst), .block(block), .jmp(jmp), .jmp_pc(jmp_pc),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
      .imem_resp_data(imem_resp_data), .imem_resp_error(imem_resp_error),
      .valid_out(valid_out), .pc_out(pc_out), .instr_out(instr_out),
      .instr_error_out(instr_error_out)
   );

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: a queue of fetched entries plus the fetch pc, a pending
   // request, an accepted-but-unanswered request and a discard mark.
   typedef struct packed {logic [63:0] pc; logic [31:0] instr; logic err;} ent_t;
   ent_t        mq[$];
   bit          m_live = 0, m_has_req = 0, m_inflight = 0, m_discard = 0;
   logic [63:0] m_fetch, m_req_pc;
   logic [31:0] m_instr;
   logic        m_err;

   // Bus responder state
   bit          bus_busy = 0, force_resp = 0;
   logic [63:0] bus_addr = 64'd0;
   int          ready_pct = 100, resp_pct = 100, err_pct = 0;
   logic        pre_req_valid;
   logic [63:0] pre_req_addr;
   bit          last_handoff;
   logic [63:0] last_pc;

   function automatic logic [63:0] mem(input logic [63:0] a);
      if (a == 64'h8000_0000) return 64'h00A0_0093_0010_0113;
      return {a[31:0] ^ 32'h1357_9BDF, ~a[31:0]};
   endfunction

   task automatic compare();
      pre_req_valid = imem_req_valid;
      pre_req_addr  = imem_req_addr;
      last_handoff  = valid_out && !block && !jmp;
      last_pc       = pc_out;
      if (!m_live) return;
      chk("valid_out", valid_out, (mq.size() != 0) && !jmp);
      if (mq.size() != 0) chk("pc_out", pc_out, mq[0].pc);
      chk("req_valid", imem_req_valid, m_has_req);
      if (m_has_req) chk("req_addr", imem_req_addr, m_req_pc & ~64'd7);
      chk("instr_out", instr_out, m_instr);
      chk("instr_err", instr_error_out, m_err);
   endtask

   task automatic model_update();
      ent_t        e;
      bit          do_push, pop_now;
      int          occ;
      logic [63:0] sh;
      if (rst) begin
         m_live = 1; mq.delete(); m_fetch = RESET_PC; m_has_req = 0;
         m_inflight = 0; m_discard = 0; m_instr = NOP; m_err = 0;
         return;
      end
      if (!m_live) return;
      occ = mq.size();
      pop_now = (occ > 0) && !jmp && !block;
      do_push = 0;
      e = '0;
      if (pop_now) begin m_instr = mq[0].instr; m_err = mq[0].err; end
      if (m_has_req) begin
         if (imem_req_ready) begin
            m_has_req = 0; m_inflight = 1;
            if (!jmp && !m_discard) m_fetch = m_req_pc + 64'd4;
         end
         if (jmp) m_discard = 1;
      end else if (m_inflight) begin
         if (imem_resp_valid) begin
            m_inflight = 0;
            if (!jmp && !m_discard) begin
               sh = imem_resp_data >> (m_req_pc[2] ? 32 : 0);
               do_push = 1; e.pc = m_req_pc; e.instr = sh[31:0]; e.err = imem_resp_error;
            end
            m_discard = 0;
         end else if (jmp) m_discard = 1;
      end else if (occ < 2 && !jmp) begin
         if (m_fetch[1:0] == 2'b00) begin
            m_has_req = 1; m_req_pc = m_fetch;
         end else begin
            do_push = 1; e.pc = m_fetch; e.instr = NOP; e.err = 1;
            m_fetch = m_fetch + 64'd4;
         end
      end
      if (jmp) begin
         mq.delete(); m_fetch = jmp_pc;
      end else begin
         if (pop_now) void'(mq.pop_front());
         if (do_push) mq.push_back(e);
      end
   endtask

   task automatic bus_update();
      if (rst) begin bus_busy = 0; return; end
      if (bus_busy && imem_resp_valid) bus_busy = 0;
      if (pre_req_valid && imem_req_ready) begin bus_busy = 1; bus_addr = pre_req_addr; end
   endtask

   // One clock: drive bus inputs, compare, clock edge, advance model and bus.
   task automatic step();
      imem_req_ready  = ($urandom_range(99) < ready_pct);
      imem_resp_valid = force_resp || (bus_busy && ($urandom_range(99) < resp_pct));
      imem_resp_data  = bus_busy ? mem(bus_addr) : {$urandom, $urandom};
      imem_resp_error = bus_busy && ((bus_addr == ERR_ADDR) || ($urandom_range(99) < err_pct));
      #1;
      compare();
      @(posedge clk);
      model_update();
      bus_update();
      @(negedge clk);
   endtask

   task automatic run_until_handoff(input string nm, input logic [63:0] pc, input int budget);
      bit ok = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         step();
         if (last_handoff && last_pc == pc) ok = 1;
      end
      chk(nm, ok, 1);
   endtask

   task automatic wait_busy(input string nm, input int budget);
      bit ok = bus_busy;
      for (int i = 0; i < budget && !ok; i++) begin step(); ok = bus_busy; end
      chk(nm, ok, 1);
   endtask

   task automatic wait_req(input string nm, input int budget);
      bit ok = imem_req_valid;
      for (int i = 0; i < budget && !ok; i++) begin step(); ok = imem_req_valid; end
      chk(nm, ok, 1);
   endtask

   initial begin
      logic [63:0] held_pc;
      @(negedge clk);
      rst = 1; step(); step();
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_valid_out", valid_out, 0);
      chk("rst_pc_out", pc_out, 0);
      chk("rst_instr", instr_out, NOP);
      chk("rst_err", instr_error_out, 0);
      rst = 0;

      // Basic fetch with one-cycle latency
      wait_req("t1_req_seen", 10);
      chk("t1_req_addr", imem_req_addr, 64'h8000_0000);
      run_until_handoff("t1_hand0", 64'h8000_0000, 20);
      chk("t1_instr0", instr_out, 32'h0010_0113);
      run_until_handoff("t1_hand1", 64'h8000_0004, 20);
      chk("t1_instr1", instr_out, 32'h00A0_0093);

      // Decode stall with a full queue
      block = 1;
      for (int i = 0; i < 8; i++) step();
      held_pc = pc_out;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t2_req_idle", imem_req_valid, 0);
         chk("t2_valid", valid_out, 1);
         chk("t2_pc_stable", pc_out, held_pc);
      end
      block = 0;
      for (int i = 0; i < 6; i++) step();

      // Redirect while waiting, response three cycles later
      resp_pct = 0;
      wait_busy("t3_busy", 30);
      jmp = 1; jmp_pc = 64'h8000_0100;
      #1 chk("t3_valid_in_jmp", valid_out, 0);
      step(); jmp = 0;
      step(); step();
      resp_pct = 100;
      step();
      wait_req("t3_req_seen", 20);
      chk("t3_req_addr", imem_req_addr, 64'h8000_0100);

      // Redirect in the same cycle as the response
      resp_pct = 0;
      wait_busy("t4_busy", 30);
      jmp = 1; jmp_pc = 64'h8000_0200; resp_pct = 100;
      step(); jmp = 0;
      chk("t4_idle", imem_req_valid, 0);
      step();
      chk("t4_req", imem_req_valid, 1);
      chk("t4_req_addr", imem_req_addr, 64'h8000_0200);

      // Misaligned redirect target
      jmp = 1; jmp_pc = 64'h8000_0102;
      step(); jmp = 0;
      run_until_handoff("t5_hand0", 64'h8000_0102, 30);
      chk("t5_instr", instr_out, NOP);
      chk("t5_err", instr_error_out, 1);
      run_until_handoff("t5_hand1", 64'h8000_0106, 10);
      chk("t5_err1", instr_error_out, 1);
      chk("t5_no_req", imem_req_valid, 0);

      // Bus fault, then reset mid-wait with a late response
      jmp = 1; jmp_pc = ERR_ADDR;
      step(); jmp = 0;
      run_until_handoff("t6_hand", ERR_ADDR, 30);
      chk("t6_err", instr_error_out, 1);
      resp_pct = 0;
      wait_busy("t6_busy", 30);
      rst = 1; step(); rst = 0;
      chk("t6_rst_valid", valid_out, 0);
      chk("t6_rst_instr", instr_out, NOP);
      force_resp = 1; step(); force_resp = 0;
      resp_pct = 100;
      wait_req("t6_req_seen", 20);
      chk("t6_req_addr", imem_req_addr, RESET_PC);

      // Fetch pc wrap-around
      jmp = 1; jmp_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      step(); jmp = 0;
      run_until_handoff("wrap_top", 64'hFFFF_FFFF_FFFF_FFFC, 40);
      run_until_handoff("wrap_zero", 64'd0, 40);

      // Randomized traffic
      ready_pct = 60; resp_pct = 50; err_pct = 5;
      for (int i = 0; i < 3000; i++) begin
         rst   = ($urandom_range(999) < 3);
         block = ($urandom_range(99) < 30);
         jmp   = ($urandom_range(99) < 4);
         case ($urandom_range(5))
            0, 1, 2: jmp_pc = RESET_PC + 64'($urandom_range(31)) * 64'd8;
            3:       jmp_pc = RESET_PC + 64'($urandom_range(31)) * 64'd8 + 64'd4;
            4:       jmp_pc = 64'hFFFF_FFFF_FFFF_FFF8;
            default: jmp_pc = RESET_PC + 64'd2;
         endcase
         step();
      end
      rst = 0; block = 0; jmp = 0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
